// File: rtl/booth4_mult_ctrl_pkg.sv
// Shared definitions for the radix-4 Booth multiplier controller.
//   state_t        : controller states (IDLE, RUN, DONE)
//   ITER/ACC_W/P_W : iteration count, accumulator width, partial-product register width
//   booth_digit_t  : recoded Booth digit selecting 0, +/-M or +/-2M
//   booth_recode() : maps the low three bits of P to a Booth digit
package booth4_mult_ctrl_pkg;

    localparam int ITER  = 16;
    localparam int ACC_W = 34;
    localparam int P_W   = 67;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        BD_ZERO   = 3'd0,
        BD_POS_M  = 3'd1,
        BD_POS_2M = 3'd2,
        BD_NEG_2M = 3'd3,
        BD_NEG_M  = 3'd4
    } booth_digit_t;

    function automatic booth_digit_t booth_recode(input logic [2:0] bits);
        booth_digit_t digit;
        case (bits)
            3'b001, 3'b010: digit = BD_POS_M;
            3'b011:         digit = BD_POS_2M;
            3'b100:         digit = BD_NEG_2M;
            3'b101, 3'b110: digit = BD_NEG_M;
            default:        digit = BD_ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth4_mult_ctrl_shift.sv
// Purely combinational 67-bit arithmetic shift right by two.
//   din  : 67-bit value (adder output of the Booth step)
//   dout : din >>> 2, sign bit replicated into both vacated MSBs
module shift_ars2_67
    import booth4_mult_ctrl_pkg::*;
(
    input  logic [P_W-1:0] din,
    output logic [P_W-1:0] dout
);

    assign dout = {din[P_W-1], din[P_W-1], din[P_W-1:2]};

endmodule

// File: rtl/booth4_mult_ctrl.sv
// Sequential radix-4 Booth multiplier, 32x32 signed, one digit per cycle.
//   clock          : rising-edge clock
//   reset          : asynchronous active-high reset
//   ctrl_MULT      : start request, honoured in IDLE or DONE
//   data_operandA  : signed multiplicand, captured on accepted start
//   data_operandB  : signed multiplier, captured on accepted start
//   data_result    : low 32 bits of the product, held until the next DONE
//   data_exception : product does not fit in 32 signed bits
//   data_resultRDY : one-cycle pulse in DONE
//   busy           : high in RUN
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | one Booth digit per cycle, ITER cycles
// DONE  | result valid, RDY pulses; may accept a new start
module booth4_mult_ctrl #(
    parameter int ITER = booth4_mult_ctrl_pkg::ITER
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    import booth4_mult_ctrl_pkg::*;

    state_t             state_q, state_d;
    logic [P_W-1:0]     p_q, p_d;
    logic [ACC_W-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    booth_digit_t       digit;
    logic [ACC_W-1:0]   m2;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   acc_sum;
    logic [P_W-1:0]     p_sum;
    logic [P_W-1:0]     p_shift;
    logic [P_W-33:0]    p_high;

    // Booth step datapath: add the selected multiple to the accumulator
    // (modulo 2^ACC_W) and hand the full register to the shifter.
    always_comb begin
        digit = booth_recode(p_q[2:0]);
        m2    = {m_q[ACC_W-2:0], 1'b0};
        case (digit)
            BD_POS_M:  addend = m_q;
            BD_POS_2M: addend = m2;
            BD_NEG_2M: addend = -m2;
            BD_NEG_M:  addend = -m_q;
            default:   addend = '0;
        endcase
        acc_sum = p_q[P_W-1:P_W-ACC_W] + addend;
        p_sum   = {acc_sum, p_q[P_W-ACC_W-1:0]};
    end

    shift_ars2_67 u_shift (
        .din  (p_sum),
        .dout (p_shift)
    );

    // Bits above the 32-bit signed range, plus its sign bit; all equal
    // means the product fits.
    assign p_high = p_shift[P_W-1:32];

    always_comb begin
        state_d  = state_q;
        p_d      = p_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            RUN: begin
                p_d   = p_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d  = DONE;
                    result_d = p_shift[32:1];
                    exc_d    = !((p_high == '0) || (p_high == '1));
                    rdy_d    = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a start; DONE otherwise falls back to IDLE.
                if (ctrl_MULT) begin
                    state_d = RUN;
                    m_d     = {{(ACC_W-32){data_operandA[31]}}, data_operandA};
                    p_d     = {{ACC_W{1'b0}}, data_operandB, 1'b0};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_booth4_mult_ctrl.sv
module tb_booth4_mult_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res;
    logic        last_exc;
    logic [31:0] exp_res;
    logic        exp_exc;

    always #5 clock = ~clock;

    booth4_mult_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Reference: full signed product, low word, and whether it fits in 32 signed bits.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint prod;
        longint low_sext;
        prod     = longint'($signed(a)) * longint'($signed(b));
        low_sext = longint'($signed(prod[31:0]));
        return {(prod != low_sext), prod[31:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        {exp_exc, exp_res} = model(a, b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        tick();
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Walk cycles 1..16 after acceptance, optionally pulsing a start that must
    // be ignored, then check the DONE cycle (cycle 17). Returns inside DONE.
    task automatic expect_done(input int kick, input logic [31:0] ka, input logic [31:0] kb);
        for (int c = 1; c <= 16; c++) begin
            chk("busy_run", {31'b0, busy}, 32'd1);
            chk("rdy_run", {31'b0, data_resultRDY}, 32'd0);
            chk("res_hold", data_result, last_res);
            chk("exc_hold", {31'b0, data_exception}, {31'b0, last_exc});
            if (c == kick) begin
                ctrl_MULT     = 1'b1;
                data_operandA = ka;
                data_operandB = kb;
            end
            tick();
            if (c == kick) begin
                ctrl_MULT     = 1'b0;
                data_operandA = $urandom;
                data_operandB = $urandom;
            end
        end
        chk("rdy_done", {31'b0, data_resultRDY}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("result", data_result, exp_res);
        chk("exception", {31'b0, data_exception}, {31'b0, exp_exc});
        last_res = exp_res;
        last_exc = exp_exc;
    endtask

    task automatic idle_after();
        tick();
        chk("rdy_idle", {31'b0, data_resultRDY}, 32'd0);
        chk("busy_idle", {31'b0, busy}, 32'd0);
        chk("res_idle", data_result, last_res);
        chk("exc_idle", {31'b0, data_exception}, {31'b0, last_exc});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_res"}, data_result, 32'd0);
        chk({tag, "_exc"}, {31'b0, data_exception}, 32'd0);
        chk({tag, "_rdy"}, {31'b0, data_resultRDY}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          kick;

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        last_res      = '0;
        last_exc      = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("reset");
        tick();
        tick();
        chk_zero("reset_hold");
        reset = 1'b0;

        // Start right after reset release, basic product
        launch(32'd3, 32'd5);
        expect_done(0, '0, '0);
        chk("basic_lit", data_result, 32'd15);
        idle_after();

        launch(32'hFFFF_FFF9, 32'd6);
        expect_done(0, '0, '0);
        chk("neg_lit", data_result, 32'hFFFF_FFD6);
        idle_after();

        launch(32'h8000_0000, 32'hFFFF_FFFF);
        expect_done(0, '0, '0);
        chk("ovf1_lit", data_result, 32'h8000_0000);
        chk("ovf1_exc", {31'b0, data_exception}, 32'd1);
        idle_after();

        launch(32'h7FFF_FFFF, 32'd2);
        expect_done(0, '0, '0);
        chk("ovf2_lit", data_result, 32'hFFFF_FFFE);
        chk("ovf2_exc", {31'b0, data_exception}, 32'd1);
        idle_after();

        // Start during RUN is ignored
        launch(32'd100, 32'hFFFF_FFFD);
        expect_done(5, 32'd1, 32'd1);
        chk("busy_lit", data_result, 32'hFFFF_FED4);
        idle_after();

        // Back-to-back from DONE
        launch(32'd2, 32'd3);
        expect_done(0, '0, '0);
        chk("b2b1_lit", data_result, 32'd6);
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_done(0, '0, '0);
        chk("b2b2_lit", data_result, 32'd1);
        idle_after();

        // Reset in cycle 8 of an operation
        launch(32'h1234_5678, 32'h0BAD_F00D);
        for (int c = 1; c < 8; c++) tick();
        reset = 1'b1;
        #1 chk_zero("midrst");
        tick();
        chk_zero("midrst_hold");
        reset    = 1'b0;
        last_res = '0;
        last_exc = 1'b0;
        launch(32'hFFFF_FC18, 32'd12345);
        expect_done(0, '0, '0);
        idle_after();

        // Randomized operations with random ignored starts and random chaining
        for (int i = 0; i < 30; i++) begin
            ra   = pick_operand();
            rb   = pick_operand();
            kick = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
            launch(ra, rb);
            expect_done(kick, $urandom, $urandom);
            if ($urandom_range(0, 1) == 0) idle_after();
        end
        idle_after();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
